// File: rtl/apb_spi_regbank_if.sv
// APB3 bus bundle between the interconnect (master) and the SPI register bank (slave).
interface apb_spi_regbank_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_spi_regbank.sv
// APB3 register bank for the SPI peripheral: control/status registers, RX holding
// register with overrun detection, TX FIFO towards the shift engine, level interrupt.
module apb_spi_regbank #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int RX_W        = 10,
   parameter int TX_W        = 8,
   parameter int TX_DEPTH    = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              presetn,
   apb_spi_regbank_if.slave  apb,
   output logic              spi_enable,
   input  logic              spi_busy,
   input  logic [RX_W-1:0]   spi_rx_data,
   input  logic              spi_rx_valid,
   output logic [TX_W-1:0]   spi_tx_data,
   output logic              spi_tx_valid,
   input  logic              spi_tx_ready,
   output logic              irq
);
   localparam int PTR_W = $clog2(TX_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WS_W  = $clog2(WAIT_STATES + 1) + 1;

   localparam logic [WS_W-1:0]   WS_LAST  = WS_W'(WAIT_STATES);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h04);
   localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h08);
   localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h0C);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t            state_r;
   logic [WS_W-1:0]   wait_cnt_r;
   logic [ADDR_W-1:0] addr_r;
   logic              write_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] prdata_r;
   logic              pready_r;
   logic              pslverr_r;

   logic              ctrl_en_r;
   logic              rx_ie_r;
   logic              tx_ie_r;
   logic [RX_W-1:0]   rx_reg_r;
   logic              rx_valid_r;
   logic              rx_ovr_r;
   logic              spi_enable_r;
   logic              irq_r;

   logic [TX_W-1:0]   mem_r [TX_DEPTH];
   logic [CNT_W-1:0]  wr_ptr_r;
   logic [CNT_W-1:0]  rd_ptr_r;

   logic [CNT_W-1:0]  level_s;
   logic              empty_s;
   logic              full_s;
   logic              tx_valid_s;
   logic              pop_s;
   logic              setup_s;
   logic              commit_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic              acc_write_s;
   logic [DATA_W-1:0] acc_wdata_s;
   logic [DATA_W-1:0] rdata_s;
   logic              err_s;
   logic              ok_s;
   logic              wr_ctrl_s;
   logic              w1c_s;
   logic              rd_rx_s;
   logic              push_s;
   logic              flush_s;
   logic              unused_s;

   // Pointers carry a wrap bit, so the difference is the fill level directly.
   assign level_s    = wr_ptr_r - rd_ptr_r;
   assign empty_s    = (wr_ptr_r == rd_ptr_r);
   assign full_s     = (level_s == CNT_W'(TX_DEPTH));
   assign tx_valid_s = !empty_s && ctrl_en_r;
   assign pop_s      = tx_valid_s && spi_tx_ready;
   assign setup_s    = (state_r == S_IDLE) && apb.psel && !apb.penable;

   // In IDLE the access is taken straight from the bus; afterwards from the setup latch.
   assign acc_addr_s  = (state_r == S_IDLE) ? apb.paddr  : addr_r;
   assign acc_write_s = (state_r == S_IDLE) ? apb.pwrite : write_r;
   assign acc_wdata_s = (state_r == S_IDLE) ? apb.pwdata : wdata_r;

   // Commit fires on the edge that moves the FSM into READY.
   always_comb begin
      commit_s = 1'b0;
      case (state_r)
         S_IDLE:  commit_s = setup_s && (WAIT_STATES == 32'sd0);
         S_WAIT:  commit_s = apb.psel && ((wait_cnt_r + WS_W'(1)) == WS_LAST);
         default: commit_s = 1'b0;
      endcase
   end

   // Address decode, read mux and error classification on pre-edge state.
   always_comb begin
      rdata_s = {DATA_W{1'b0}};
      err_s   = 1'b0;
      case (acc_addr_s)
         A_CTRL: begin
            rdata_s[2:0] = {tx_ie_r, rx_ie_r, ctrl_en_r};
         end
         A_STATUS: begin
            rdata_s[4:0]       = {rx_ovr_r, rx_valid_r, empty_s, full_s, spi_busy};
            rdata_s[8 +: CNT_W] = level_s;
         end
         A_RXDATA: begin
            rdata_s[RX_W-1:0] = rx_reg_r;
            err_s             = acc_write_s;
         end
         A_TXDATA: begin
            err_s = !acc_write_s || full_s;
         end
         default: begin
            err_s = 1'b1;
         end
      endcase
   end

   assign ok_s      = commit_s && !err_s;
   assign wr_ctrl_s = ok_s && acc_write_s && (acc_addr_s == A_CTRL);
   assign w1c_s     = ok_s && acc_write_s && (acc_addr_s == A_STATUS) && acc_wdata_s[4];
   assign rd_rx_s   = ok_s && !acc_write_s && (acc_addr_s == A_RXDATA);
   assign push_s    = ok_s && acc_write_s && (acc_addr_s == A_TXDATA);
   assign flush_s   = wr_ctrl_s && acc_wdata_s[3];
   assign unused_s  = ^acc_wdata_s;

   // APB access FSM with registered PREADY/PSLVERR/PRDATA.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_r    <= S_IDLE;
         wait_cnt_r <= {WS_W{1'b0}};
         addr_r     <= {ADDR_W{1'b0}};
         write_r    <= 1'b0;
         wdata_r    <= {DATA_W{1'b0}};
         prdata_r   <= {DATA_W{1'b0}};
         pready_r   <= 1'b0;
         pslverr_r  <= 1'b0;
      end else begin
         if (commit_s) begin
            pready_r  <= 1'b1;
            pslverr_r <= err_s;
            prdata_r  <= (err_s || acc_write_s) ? {DATA_W{1'b0}} : rdata_s;
         end else begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= {DATA_W{1'b0}};
         end
         case (state_r)
            S_IDLE: begin
               if (setup_s) begin
                  addr_r     <= apb.paddr;
                  write_r    <= apb.pwrite;
                  wdata_r    <= apb.pwdata;
                  wait_cnt_r <= {WS_W{1'b0}};
                  state_r    <= (WAIT_STATES == 32'sd0) ? S_READY : S_WAIT;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (!apb.psel) begin
                  wait_cnt_r <= {WS_W{1'b0}};
                  state_r    <= S_IDLE;
               end else if (commit_s) begin
                  wait_cnt_r <= {WS_W{1'b0}};
                  state_r    <= S_READY;
               end else begin
                  wait_cnt_r <= wait_cnt_r + WS_W'(1);
               end
            end
            S_READY: begin
               state_r <= S_IDLE;
            end
            default: begin
               wait_cnt_r <= {WS_W{1'b0}};
               state_r    <= S_IDLE;
            end
         endcase
      end
   end

   // TX FIFO: fullness is judged pre-edge, and flush overrides a concurrent pop.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         wr_ptr_r <= {CNT_W{1'b0}};
         rd_ptr_r <= {CNT_W{1'b0}};
         for (int i = 0; i < TX_DEPTH; i++) begin
            mem_r[i] <= {TX_W{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= acc_wdata_s[TX_W-1:0];
            wr_ptr_r                  <= wr_ptr_r + CNT_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
         end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + CNT_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Control bits, RX holding register with overrun, enable and interrupt registers.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         ctrl_en_r    <= 1'b0;
         rx_ie_r      <= 1'b0;
         tx_ie_r      <= 1'b0;
         rx_reg_r     <= {RX_W{1'b0}};
         rx_valid_r   <= 1'b0;
         rx_ovr_r     <= 1'b0;
         spi_enable_r <= 1'b0;
         irq_r        <= 1'b0;
      end else begin
         if (wr_ctrl_s) begin
            ctrl_en_r <= acc_wdata_s[0];
            rx_ie_r   <= acc_wdata_s[1];
            tx_ie_r   <= acc_wdata_s[2];
         end else begin
            ctrl_en_r <= ctrl_en_r;
         end
         if (spi_rx_valid) begin
            rx_reg_r   <= spi_rx_data;
            rx_valid_r <= 1'b1;
         end else if (rd_rx_s) begin
            rx_valid_r <= 1'b0;
         end else begin
            rx_valid_r <= rx_valid_r;
         end
         // A read landing on the capture edge consumes the old word, so no overrun.
         if (spi_rx_valid && rx_valid_r && !rd_rx_s) begin
            rx_ovr_r <= 1'b1;
         end else if (w1c_s) begin
            rx_ovr_r <= 1'b0;
         end else begin
            rx_ovr_r <= rx_ovr_r;
         end
         spi_enable_r <= ctrl_en_r;
         irq_r        <= (rx_ie_r && rx_valid_r) || (tx_ie_r && ctrl_en_r && empty_s) || rx_ovr_r;
      end
   end

   assign apb.prdata   = prdata_r;
   assign apb.pready   = pready_r;
   assign apb.pslverr  = pslverr_r;
   assign spi_enable   = spi_enable_r;
   assign spi_tx_valid = tx_valid_s;
   assign spi_tx_data  = mem_r[rd_ptr_r[PTR_W-1:0]];
   assign irq          = irq_r;
endmodule

// File: tb/tb_apb_spi_regbank.sv
// Randomised and directed bench for apb_spi_regbank against a queue-based register model;
// a second instance with two wait states covers access timing and aborts.
module tb_apb_spi_regbank;
   localparam int DEPTH = 4;

   logic       pclk;
   logic       presetn;
   int         checks = 0;
   int         errors = 0;

   logic       spi_enable, spi_busy, spi_rx_valid, spi_tx_valid, spi_tx_ready, irq;
   logic [9:0] spi_rx_data;
   logic [7:0] spi_tx_data;
   logic       w_spi_enable, w_spi_tx_valid, w_irq;
   logic [7:0] w_spi_tx_data;
   logic       w_zero;
   logic [9:0] w_zero_rx;

   apb_spi_regbank_if #(.ADDR_W(8), .DATA_W(16)) bus ();
   apb_spi_regbank_if #(.ADDR_W(8), .DATA_W(16)) wbus ();

   apb_spi_regbank #(.WAIT_STATES(0)) dut (
      .pclk(pclk), .presetn(presetn), .apb(bus),
      .spi_enable(spi_enable), .spi_busy(spi_busy),
      .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
      .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
      .spi_tx_ready(spi_tx_ready), .irq(irq)
   );

   apb_spi_regbank #(.WAIT_STATES(2)) dut_w (
      .pclk(pclk), .presetn(presetn), .apb(wbus),
      .spi_enable(w_spi_enable), .spi_busy(w_zero),
      .spi_rx_data(w_zero_rx), .spi_rx_valid(w_zero),
      .spi_tx_data(w_spi_tx_data), .spi_tx_valid(w_spi_tx_valid),
      .spi_tx_ready(w_zero), .irq(w_irq)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Reference model state
   logic [7:0] txq[$];
   logic       m_en, m_rxie, m_txie, m_rxv, m_ovr;
   logic [9:0] m_rx_reg;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      m_en = 1'b0; m_rxie = 1'b0; m_txie = 1'b0;
      m_rxv = 1'b0; m_ovr = 1'b0; m_rx_reg = 10'd0;
   endtask

   task automatic model_rx(input logic cap, input logic [9:0] d, input logic rd_clear);
      if (cap) begin
         if (m_rxv && !rd_clear) m_ovr = 1'b1;
         m_rx_reg = d;
         m_rxv    = 1'b1;
      end else if (rd_clear) begin
         m_rxv = 1'b0;
      end
   endtask

   task automatic model_commit(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                               input logic pop, input logic cap, input logic [9:0] capd,
                               input logic busy, output logic [15:0] exp_rd, output logic exp_err);
      logic full_pre, empty_pre, pop_do, rd_clear;
      full_pre  = (txq.size() == DEPTH);
      empty_pre = (txq.size() == 0);
      pop_do    = pop && m_en && !empty_pre;
      exp_rd    = 16'h0000;
      exp_err   = 1'b0;
      case (addr)
         8'h00: if (!wr) exp_rd = {13'd0, m_txie, m_rxie, m_en};
         8'h04: if (!wr) exp_rd = {5'd0, 3'(txq.size()), 3'd0, m_ovr, m_rxv, empty_pre, full_pre, busy};
         8'h08: if (wr) exp_err = 1'b1; else exp_rd = {6'd0, m_rx_reg};
         8'h0C: if (!wr || full_pre) exp_err = 1'b1;
         default: exp_err = 1'b1;
      endcase
      rd_clear = !exp_err && !wr && (addr == 8'h08);
      if (!exp_err && wr && addr == 8'h04 && wd[4]) m_ovr = 1'b0;
      model_rx(cap, capd, rd_clear);
      if (!exp_err && wr && addr == 8'h00 && wd[3]) txq.delete();
      else if (pop_do) void'(txq.pop_front());
      if (!exp_err && wr && addr == 8'h00) begin
         m_en = wd[0]; m_rxie = wd[1]; m_txie = wd[2];
      end
      if (!exp_err && wr && addr == 8'h0C) txq.push_back(wd[7:0]);
   endtask

   task automatic check_outputs(input string tag);
      logic empty;
      empty = (txq.size() == 0);
      check_value({tag, "/spi_enable"}, spi_enable, m_en);
      check_value({tag, "/tx_valid"}, spi_tx_valid, m_en && !empty);
      if (!empty) check_value({tag, "/tx_data"}, spi_tx_data, txq[0]);
      check_value({tag, "/irq"}, irq, (m_rxie && m_rxv) || (m_txie && m_en && empty) || m_ovr);
   endtask

   // One APB transfer on the zero-wait instance; starts and ends #1 after an edge in IDLE.
   task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [15:0] wd, input logic pop, input logic cap,
                           input logic [9:0] capd, output logic [15:0] got);
      logic [15:0] exp_rd;
      logic        exp_err;
      int          lat;
      check_value({tag, "/pready_setup"}, bus.pready, 1'b0);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
      spi_tx_ready = pop; spi_rx_valid = cap; spi_rx_data = capd;
      model_commit(wr, addr, wd, pop, cap, capd, spi_busy, exp_rd, exp_err);
      @(posedge pclk); #1;
      spi_tx_ready = 1'b0; spi_rx_valid = 1'b0; bus.penable = 1'b1;
      lat = 1;
      while (!bus.pready && lat < 8) begin
         @(posedge pclk); #1;
         lat++;
      end
      check_value({tag, "/latency"}, lat, 1);
      check_value({tag, "/pslverr"}, bus.pslverr, exp_err);
      check_value({tag, "/prdata"}, bus.prdata, exp_rd);
      got = bus.prdata;
      @(posedge pclk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0;
      check_value({tag, "/pready_drop"}, bus.pready, 1'b0);
      check_outputs(tag);
   endtask

   task automatic rx_strobe(input logic [9:0] d);
      spi_rx_valid = 1'b1; spi_rx_data = d;
      model_rx(1'b1, d, 1'b0);
      @(posedge pclk); #1;
      spi_rx_valid = 1'b0;
   endtask

   task automatic drain_one(input string tag);
      check_outputs({tag, "/pre"});
      spi_tx_ready = 1'b1;
      @(posedge pclk); #1;
      spi_tx_ready = 1'b0;
      if (m_en && txq.size() > 0) void'(txq.pop_front());
      @(posedge pclk); #1;
      check_outputs({tag, "/post"});
   endtask

   // Transfer on the two-wait-state instance; abort_at>0 drops PSEL after that many access cycles.
   task automatic w_xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                         input int abort_at, output int lat, output logic [15:0] rd, output logic err);
      wbus.psel = 1'b1; wbus.penable = 1'b0; wbus.pwrite = wr; wbus.paddr = addr; wbus.pwdata = wd;
      @(posedge pclk); #1;
      wbus.penable = 1'b1;
      lat = 1; rd = 16'h0000; err = 1'b0;
      while (!wbus.pready && lat < 10) begin
         if (abort_at != 0 && lat == abort_at) begin
            wbus.psel = 1'b0; wbus.penable = 1'b0;
         end
         @(posedge pclk); #1;
         lat++;
      end
      if (wbus.pready) begin
         rd = wbus.prdata; err = wbus.pslverr;
         @(posedge pclk); #1;
      end else begin
         lat = 0;
      end
      wbus.psel = 1'b0; wbus.penable = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      logic        err;
      logic [15:0] wd;
      logic [7:0]  addr;
      int          lat;
      int          op;

      presetn = 1'b0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h00; bus.pwdata = 16'h0000;
      wbus.psel = 1'b0; wbus.penable = 1'b0; wbus.pwrite = 1'b0; wbus.paddr = 8'h00; wbus.pwdata = 16'h0000;
      spi_busy = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = 10'd0; spi_tx_ready = 1'b0;
      w_zero = 1'b0; w_zero_rx = 10'd0;
      model_reset();
      @(posedge pclk); @(posedge pclk); #1;
      check_value("rst/prdata", bus.prdata, 16'h0000);
      check_value("rst/pready", bus.pready, 1'b0);
      check_value("rst/pslverr", bus.pslverr, 1'b0);
      check_value("rst/tx_data", spi_tx_data, 8'h00);
      check_outputs("rst");
      presetn = 1'b1;
      @(posedge pclk); #1;

      apb_xfer("rd_ctrl0", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("rd_ctrl0/const", rd, 16'h0000);
      apb_xfer("rd_stat0", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("rd_stat0/const", rd, 16'h0004);
      apb_xfer("rd_rx0", 1'b0, 8'h08, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("rd_rx0/const", rd, 16'h0000);

      // Fill the FIFO with the engine stalled, overflow once, then drain in order.
      apb_xfer("en", 1'b1, 8'h00, 16'h0001, 1'b0, 1'b0, 10'd0, rd);
      for (int i = 1; i <= 4; i++) apb_xfer("push", 1'b1, 8'h0C, 16'(8'hA0 + i), 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("st_full", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_full/const", rd, 16'h0402);
      apb_xfer("push5", 1'b1, 8'h0C, 16'h00A5, 1'b0, 1'b0, 10'd0, rd);
      for (int i = 1; i <= 4; i++) begin
         check_value("drain/order", spi_tx_data, 32'(8'hA0 + i));
         drain_one("drain");
      end
      apb_xfer("st_empty", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_empty/const", rd, 16'h0004);

      // Simultaneous push/pop at level 2, then a rejected push while full with a pop.
      apb_xfer("b1", 1'b1, 8'h0C, 16'h00B1, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("b2", 1'b1, 8'h0C, 16'h00B2, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("b3pop", 1'b1, 8'h0C, 16'h00B3, 1'b1, 1'b0, 10'd0, rd);
      apb_xfer("st_l2", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_l2/const", rd, 16'h0200);
      apb_xfer("b4", 1'b1, 8'h0C, 16'h00B4, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("b5", 1'b1, 8'h0C, 16'h00B5, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("b6full", 1'b1, 8'h0C, 16'h00B6, 1'b1, 1'b0, 10'd0, rd);
      apb_xfer("st_l3", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_l3/const", rd, 16'h0300);
      apb_xfer("flushpop", 1'b1, 8'h00, 16'h0009, 1'b1, 1'b0, 10'd0, rd);
      apb_xfer("st_flush", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_flush/const", rd, 16'h0004);
      apb_xfer("rd_ctrl1", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("rd_ctrl1/const", rd, 16'h0001);

      // Overrun and interrupt lag.
      apb_xfer("ctrl0", 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 10'd0, rd);
      rx_strobe(10'h155);
      rx_strobe(10'h2AA);
      check_value("ovr/irq_before", irq, 1'b0);
      @(posedge pclk); #1;
      check_value("ovr/irq_after", irq, 1'b1);
      apb_xfer("st_ovr", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_ovr/const", rd, 16'h001C);
      apb_xfer("rd_ovr", 1'b0, 8'h08, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("rd_ovr/const", rd, 16'h02AA);
      apb_xfer("w1c", 1'b1, 8'h04, 16'h0010, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("st_w1c", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_w1c/const", rd, 16'h0004);
      rx_strobe(10'h111);
      apb_xfer("rd_cap", 1'b0, 8'h08, 16'h0, 1'b0, 1'b1, 10'h222, rd);
      check_value("rd_cap/const", rd, 16'h0111);
      apb_xfer("st_cap", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_cap/const", rd, 16'h000C);
      apb_xfer("w1c_cap", 1'b1, 8'h04, 16'h0010, 1'b0, 1'b1, 10'h333, rd);
      apb_xfer("st_setwin", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("st_setwin/const", rd, 16'h001C);

      // Illegal accesses.
      apb_xfer("unmapped", 1'b1, 8'h10, 16'h0007, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("rd_tx", 1'b0, 8'h0C, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("wr_rx", 1'b1, 8'h08, 16'h0055, 1'b0, 1'b0, 10'd0, rd);
      apb_xfer("st_err", 1'b0, 8'h04, 16'h0, 1'b0, 1'b0, 10'd0, rd);

      // Reset landing on a commit edge: nothing commits.
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h00; bus.pwdata = 16'h0007;
      presetn = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1; bus.psel = 1'b0;
      model_reset();
      check_value("rst_mid/pready", bus.pready, 1'b0);
      check_value("rst_mid/tx_data", spi_tx_data, 8'h00);
      @(posedge pclk); #1;
      apb_xfer("rst_mid_ctrl", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 10'd0, rd);
      check_value("rst_mid_ctrl/const", rd, 16'h0000);

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         spi_busy = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 9);
         case (op)
            0: apb_xfer("r_rdctrl", 1'b0, 8'h00, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 10'($urandom), rd);
            1: begin
               wd = 16'($urandom) & 16'hFFF7;
               if ($urandom_range(0, 7) == 0) wd[3] = 1'b1;
               apb_xfer("r_wrctrl", 1'b1, 8'h00, wd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 10'($urandom), rd);
            end
            2: apb_xfer("r_rdstat", 1'b0, 8'h04, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 10'($urandom), rd);
            3: apb_xfer("r_wrstat", 1'b1, 8'h04, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 10'($urandom), rd);
            4: apb_xfer("r_rdrx", 1'b0, 8'h08, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 10'($urandom), rd);
            5, 6: apb_xfer("r_push", 1'b1, 8'h0C, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 10'($urandom), rd);
            7: begin
               case ($urandom_range(0, 2))
                  0: addr = 8'($urandom_range(16, 255));
                  1: addr = 8'h08;
                  default: addr = 8'h0C;
               endcase
               apb_xfer("r_err", (addr != 8'h0C) && ($urandom_range(0, 1) == 1 || addr == 8'h08), addr, 16'($urandom),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 10'($urandom), rd);
            end
            8: begin
               rx_strobe(10'($urandom));
               @(posedge pclk); #1;
               check_outputs("r_rx");
            end
            default: drain_one("r_drain");
         endcase
      end

      // Two-wait-state instance: timing, status and abort.
      w_xfer(1'b1, 8'h0C, 16'h005A, 0, lat, rd, err);
      check_value("w_push/latency", lat, 3);
      check_value("w_push/pslverr", err, 1'b0);
      w_xfer(1'b0, 8'h04, 16'h0, 0, lat, rd, err);
      check_value("w_stat/latency", lat, 3);
      check_value("w_stat/prdata", rd, 16'h0100);
      w_xfer(1'b1, 8'h0C, 16'h005B, 2, lat, rd, err);
      check_value("w_abort/no_pready", lat, 0);
      w_xfer(1'b0, 8'h04, 16'h0, 0, lat, rd, err);
      check_value("w_abort/level", rd, 16'h0100);
      check_value("w_abort/tx_valid", w_spi_tx_valid, 1'b0);
      w_xfer(1'b0, 8'h20, 16'h0, 0, lat, rd, err);
      check_value("w_unmapped/pslverr", err, 1'b1);
      check_value("w_unmapped/prdata", rd, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
